// File: rtl/mnist_argmax.sv
// mnist_argmax: picks the winning digit from ten signed class scores.
// A frame is captured in one cycle, scanned one class per cycle, then held
// until the downstream takes it.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a frame; in_ready=1
// SCAN  | compare buffer[idx] against best, idx = 1..NCLS-1
// DONE  | result presented on digit/max_score; out_valid=1
module mnist_argmax #(
    parameter int SCORE_W = 32,
    parameter int NCLS    = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCLS*SCORE_W-1:0] scores,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [3:0]              digit,
    output logic [SCORE_W-1:0]      max_score,
    output logic [15:0]             frame_cnt
);

    localparam logic [3:0] LAST_IDX = 4'(NCLS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic signed [SCORE_W-1:0] buffer [NCLS];
    logic signed [SCORE_W-1:0] best;
    logic [3:0]                best_idx;
    logic [3:0]                idx;

    logic signed [SCORE_W-1:0] cand;
    logic                      take;
    logic signed [SCORE_W-1:0] best_upd;
    logic [3:0]                best_idx_upd;

    // Compare the current candidate; only a strictly larger score wins, so ties keep the lower index
    always_comb begin
        cand         = buffer[idx];
        take         = (cand > best);
        best_upd     = take ? cand : best;
        best_idx_upd = take ? idx : best_idx;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = SCAN;
            SCAN:    if (idx == LAST_IDX) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Datapath: capture, running maximum, result registers and frame counter
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NCLS; k++) buffer[k] <= '0;
            best      <= '0;
            best_idx  <= '0;
            idx       <= '0;
            digit     <= '0;
            max_score <= '0;
            frame_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int k = 0; k < NCLS; k++)
                            buffer[k] <= scores[SCORE_W*k +: SCORE_W];
                        best     <= scores[SCORE_W-1:0];
                        best_idx <= 4'd0;
                        idx      <= 4'd1;
                    end
                end
                SCAN: begin
                    best     <= best_upd;
                    best_idx <= best_idx_upd;
                    idx      <= idx + 4'd1;
                    // Result registers only move when a new result is published,
                    // so they keep the last delivered value outside DONE
                    if (idx == LAST_IDX) begin
                        digit     <= best_idx_upd;
                        max_score <= best_upd;
                    end
                end
                DONE: begin
                    if (out_ready) frame_cnt <= frame_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mnist_argmax.sv
// Bench for mnist_argmax: a transaction-level reference model is checked
// against the DUT every cycle, plus literal expectations per scenario.
module tb_mnist_argmax;

    localparam int SW = 32;
    localparam int NC = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic [NC*SW-1:0] scores;
    logic             in_valid;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       digit;
    logic [SW-1:0]    max_score;
    logic [15:0]      frame_cnt;

    int n_vec = 0;
    int n_err = 0;

    mnist_argmax #(.SCORE_W(SW), .NCLS(NC)) dut (
        .clk       (clk),
        .rst       (rst),
        .scores    (scores),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .digit     (digit),
        .max_score (max_score),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference argmax: first index holding the largest signed value
    function automatic logic [35:0] ref_argmax(input logic [NC*SW-1:0] s);
        logic signed [SW-1:0] bv;
        logic signed [SW-1:0] v;
        logic [3:0]           bi;
        bv = s[SW-1:0];
        bi = 4'd0;
        for (int k = 1; k < NC; k++) begin
            v = s[SW*k +: SW];
            if (v > bv) begin
                bv = v;
                bi = 4'(k);
            end
        end
        return {bi, bv};
    endfunction

    // Transaction model: a frame is busy from accept until the handshake;
    // the result appears 9 edges after the accept edge
    logic        m_known = 1'b0;
    logic        m_busy;
    int          m_wait;
    logic [3:0]  m_res_d;
    logic [31:0] m_res_m;
    logic [3:0]  m_digit;
    logic [31:0] m_max;
    logic [15:0] m_cnt;

    always @(negedge clk) begin
        logic [35:0] r;
        if (m_known) begin
            chk("in_ready",  {31'd0, in_ready},  {31'd0, !m_busy});
            chk("out_valid", {31'd0, out_valid}, {31'd0, m_busy && m_wait == 0});
            chk("digit",     {28'd0, digit},     {28'd0, m_digit});
            chk("max_score", max_score,          m_max);
            chk("frame_cnt", {16'd0, frame_cnt}, {16'd0, m_cnt});
        end
        if (rst) begin
            m_known = 1'b1;
            m_busy  = 1'b0;
            m_wait  = 0;
            m_digit = 4'd0;
            m_max   = 32'd0;
            m_cnt   = 16'd0;
        end else if (m_known) begin
            if (!m_busy) begin
                if (in_valid) begin
                    r       = ref_argmax(scores);
                    m_res_d = r[35:32];
                    m_res_m = r[31:0];
                    m_busy  = 1'b1;
                    m_wait  = 9;
                end
            end else if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_digit = m_res_d;
                    m_max   = m_res_m;
                end
            end else if (out_ready) begin
                m_cnt++;
                m_busy = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a frame, then wait (bounded) for out_valid and check the result literally
    task automatic run_frame(input string nm, input logic [NC*SW-1:0] s,
                             input logic [3:0] exp_d, input logic [31:0] exp_m);
        int k;
        scores   = s;
        in_valid = 1'b1;
        chk({nm, " accept_ready"}, {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin
            step();
            k++;
        end
        chk({nm, " latency"}, k + 1, 32'd10);
        chk({nm, " digit"}, {28'd0, digit}, {28'd0, exp_d});
        chk({nm, " max_score"}, max_score, exp_m);
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, " in_ready"},  {31'd0, in_ready},  32'd1);
        chk({nm, " out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({nm, " digit"},     {28'd0, digit},     32'd0);
        chk({nm, " max_score"}, max_score,          32'd0);
        chk({nm, " frame_cnt"}, {16'd0, frame_cnt}, 32'd0);
    endtask

    function automatic logic [NC*SW-1:0] fill(input logic [31:0] v);
        logic [NC*SW-1:0] s;
        for (int k = 0; k < NC; k++) s[SW*k +: SW] = v;
        return s;
    endfunction

    initial begin
        logic [NC*SW-1:0] s;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        scores    = '0;
        repeat (2) step();
        check_reset_vals("reset");

        // Ascending scores, accepted in the very first cycle out of reset
        rst = 1'b0;
        for (int k = 0; k < NC; k++) s[SW*k +: SW] = 32'(k);
        run_frame("ascend", s, 4'd9, 32'd9);
        step();
        chk("ascend frame_cnt", {16'd0, frame_cnt}, 32'd1);

        // All equal negative: lowest index wins
        run_frame("ties", fill(32'hFFFF_FFFB), 4'd0, 32'hFFFF_FFFB);
        step();

        // Signed compare at the extremes
        s = fill(32'd0);
        s[SW*3 +: SW] = 32'h7FFF_FFFF;
        s[SW*7 +: SW] = 32'h8000_0000;
        run_frame("signed_a", s, 4'd3, 32'h7FFF_FFFF);
        step();
        s = fill(32'h8000_0000);
        s[SW*7 +: SW] = 32'd1;
        run_frame("signed_b", s, 4'd7, 32'd1);
        step();

        // Back-pressure: result must hold while inputs churn
        out_ready = 1'b0;
        s = fill(32'd20);
        s[SW*2 +: SW] = 32'd55;
        s[SW*8 +: SW] = 32'd55;
        run_frame("hold", s, 4'd2, 32'd55);
        for (int i = 0; i < 5; i++) begin
            scores   = {10{$urandom()}};
            in_valid = 1'($urandom_range(0, 1));
            step();
            chk("hold digit", {28'd0, digit}, 32'd2);
            chk("hold out_valid", {31'd0, out_valid}, 32'd1);
            chk("hold in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold frame_cnt", {16'd0, frame_cnt}, 32'd4);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("hold released cnt", {16'd0, frame_cnt}, 32'd5);

        // Reset in the middle of a scan aborts the frame
        scores   = fill(32'd77);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_vals("abort");
        s = fill(32'd0);
        s[SW*5 +: SW] = 32'd100;
        run_frame("after_abort", s, 4'd5, 32'd100);
        step();

        // Frame counter wrap from 0xFFFF
        force dut.frame_cnt = 16'hFFFF;
        m_cnt = 16'hFFFF;
        step();
        release dut.frame_cnt;
        step();
        chk("wrap preload", {16'd0, frame_cnt}, 32'h0000_FFFF);
        s = fill(32'd3);
        s[SW*9 +: SW] = 32'd4;
        run_frame("wrap", s, 4'd9, 32'd4);
        step();
        chk("wrap frame_cnt", {16'd0, frame_cnt}, 32'd0);

        repeat (2) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
